// File: rtl/password_lock_n_pkg.sv
// Shared types and sizing helpers for the parametrised digit-sequence lock.
package pwd_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    ADMIT,
    PROGRAM,
    LOCKOUT
  } state_t;

  // Width of a counter that must hold 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Digit 0 occupies the MSBs of a packed digit vector.
  function automatic int unsigned slot_lsb(input int unsigned digits, input int unsigned digit_w,
                                           input int unsigned idx);
    return (digits - 1 - idx) * digit_w;
  endfunction

endpackage

// File: rtl/password_lock_n_if.sv
// Board-side signal bundle of password_lock_n: switches/button in, status/display out.
interface password_lock_n_if #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned FC_W = pwd_lock_pkg::cnt_w(MAX_FAILS);

  logic                        enter_btn;
  logic [DIGIT_W-1:0]          digit_in;
  logic                        prog_req;
  logic                        admitted;
  logic                        locked;
  logic                        fail;
  logic [DIGITS-1:0]           progress;
  logic [DIGITS*DIGIT_W-1:0]   entered;
  logic [FC_W-1:0]             fail_count;
  logic                        prog_active;

  modport master (
    output enter_btn, digit_in, prog_req,
    input  admitted, locked, fail, progress, entered, fail_count, prog_active
  );

  modport slave (
    input  enter_btn, digit_in, prog_req,
    output admitted, locked, fail, progress, entered, fail_count, prog_active
  );
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sh <= '0;
    else      sh <= {sh[1:0], btn};
  end

  assign pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/password_lock_n.sv
// Digit-sequence lock: whole-sequence compare, programmable password, timeout, admit and lockout.
module password_lock_n #(
  parameter int unsigned                   DIGITS         = 4,
  parameter int unsigned                   DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]     DEFAULT_PWD    = {4'd1, 4'd7, 4'd1, 4'd2},
  parameter int unsigned                   MAX_FAILS      = 3,
  parameter int unsigned                   LOCKOUT_CYCLES = 1000,
  parameter int unsigned                   TIMEOUT_CYCLES = 500,
  parameter int unsigned                   ADMIT_CYCLES   = 100
) (
  input logic               clk,
  input logic               rst,
  password_lock_n_if.slave  bus
);
  import pwd_lock_pkg::*;

  localparam int unsigned PW    = DIGITS * DIGIT_W;
  localparam int unsigned IDX_W = cnt_w(DIGITS);
  localparam int unsigned FC_W  = cnt_w(MAX_FAILS);
  localparam int unsigned TMR_W = cnt_w(max3(LOCKOUT_CYCLES, TIMEOUT_CYCLES, ADMIT_CYCLES));

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [FC_W-1:0]   FAIL_LIMIT = FC_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0]  TO_END     = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  ADMIT_END  = TMR_W'(ADMIT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_END   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [PW-1:0]     DIGIT_MASK = PW'({DIGIT_W{1'b1}});
  localparam logic [DIGITS-1:0] SLOT0      = DIGITS'(1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [PW-1:0]     entered, entered_n, pwd, pwd_n, captured;
  logic [DIGITS-1:0] progress, progress_n, progress_cap;
  logic [FC_W-1:0]   fail_count, fail_count_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic              fail_q, fail_n;
  logic              enter_p;
  logic              last_digit;
  int unsigned       lsb;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.enter_btn),
    .pulse (enter_p)
  );

  // Datapath views of "capture digit_in into slot idx", shared by IDLE, ENTRY and PROGRAM.
  always_comb begin
    lsb          = slot_lsb(DIGITS, DIGIT_W, 32'(idx));
    captured     = (entered & ~(DIGIT_MASK << lsb)) | (PW'(bus.digit_in) << lsb);
    progress_cap = progress | (SLOT0 << idx);
    last_digit   = (idx == LAST_IDX);
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    entered_n    = entered;
    progress_n   = progress;
    pwd_n        = pwd;
    fail_count_n = fail_count;
    timer_n      = timer;
    fail_n       = 1'b0;
    unique case (state)
      IDLE, ENTRY, PROGRAM: begin
        if (enter_p) begin
          entered_n  = captured;
          progress_n = progress_cap;
          idx_n      = idx + 1'b1;
          timer_n    = '0;
          if (last_digit) begin
            if (state == PROGRAM) begin
              pwd_n      = captured;
              entered_n  = '0;
              progress_n = '0;
              idx_n      = '0;
              state_n    = IDLE;
            end else begin
              state_n = CHECK;
            end
          end else begin
            state_n = (state == IDLE) ? ENTRY : state;
          end
        end else if (state != IDLE) begin
          // Abort discards the partial entry; pwd is only written on the final digit.
          if (timer == TO_END) begin
            entered_n  = '0;
            progress_n = '0;
            idx_n      = '0;
            timer_n    = '0;
            state_n    = IDLE;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
      end
      CHECK: begin
        entered_n  = '0;
        progress_n = '0;
        idx_n      = '0;
        timer_n    = '0;
        if (entered == pwd) begin
          fail_count_n = '0;
          state_n      = ADMIT;
        end else begin
          fail_n       = 1'b1;
          fail_count_n = fail_count + 1'b1;
          state_n      = (fail_count_n == FAIL_LIMIT) ? LOCKOUT : IDLE;
        end
      end
      ADMIT: begin
        if (enter_p && bus.prog_req) begin
          timer_n = '0;
          state_n = PROGRAM;
        end else if (timer == ADMIT_END) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer == LOCK_END) begin
          timer_n      = '0;
          fail_count_n = '0;
          state_n      = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      entered    <= '0;
      progress   <= '0;
      pwd        <= DEFAULT_PWD;
      fail_count <= '0;
      timer      <= '0;
      fail_q     <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      entered    <= entered_n;
      progress   <= progress_n;
      pwd        <= pwd_n;
      fail_count <= fail_count_n;
      timer      <= timer_n;
      fail_q     <= fail_n;
    end
  end

  assign bus.admitted    = (state == ADMIT);
  assign bus.locked      = (state == LOCKOUT);
  assign bus.prog_active = (state == PROGRAM);
  assign bus.fail        = fail_q;
  assign bus.progress    = progress;
  assign bus.entered     = entered;
  assign bus.fail_count  = fail_count;
endmodule

// File: tb/tb_password_lock_n.sv
// Directed self-checking bench for password_lock_n with default parameters.
module tb_password_lock_n;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  password_lock_n_if #(.DIGITS(4), .DIGIT_W(4), .MAX_FAILS(3)) pif ();

  password_lock_n #(
    .DIGITS(4), .DIGIT_W(4), .DEFAULT_PWD(16'h1712), .MAX_FAILS(3),
    .LOCKOUT_CYCLES(1000), .TIMEOUT_CYCLES(500), .ADMIT_CYCLES(100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  int checks = 0;
  int failures = 0;
  int adm_cycles = 0;
  int lock_cycles = 0;
  int fail_cycles = 0;
  int a0, l0, f0;

  always @(negedge clk) begin
    if (pif.admitted) adm_cycles++;
    if (pif.locked)   lock_cycles++;
    if (pif.fail)     fail_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    pif.digit_in  = d;
    pif.enter_btn = 1'b1;
    cycles(4);
    pif.enter_btn = 1'b0;
    cycles(4);
  endtask

  task automatic seq(input logic [15:0] code);
    for (int i = 0; i < 4; i++) press(code[15-4*i -: 4]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_admitted"}, 32'(pif.admitted), 32'd0);
    check({tag, "_locked"}, 32'(pif.locked), 32'd0);
    check({tag, "_fail"}, 32'(pif.fail), 32'd0);
    check({tag, "_progress"}, 32'(pif.progress), 32'd0);
    check({tag, "_entered"}, 32'(pif.entered), 32'd0);
    check({tag, "_fail_count"}, 32'(pif.fail_count), 32'd0);
    check({tag, "_prog_active"}, 32'(pif.prog_active), 32'd0);
  endtask

  initial begin
    pif.enter_btn = 1'b0;
    pif.digit_in  = '0;
    pif.prog_req  = 1'b0;
    rst = 1'b0;
    cycles(3);
    check_all_zero("reset");
    rst = 1'b1;
    cycles(2);

    // Default password admits for exactly 100 cycles.
    a0 = adm_cycles;
    seq(16'h1712);
    check("t1_admitted", 32'(pif.admitted), 32'd1);
    check("t1_fail_count", 32'(pif.fail_count), 32'd0);
    cycles(120);
    check("t1_admit_len", 32'(adm_cycles - a0), 32'd100);
    check("t1_admit_end", 32'(pif.admitted), 32'd0);
    check("t1_progress", 32'(pif.progress), 32'd0);

    // Wrong digit only judged after the 4th.
    f0 = fail_cycles;
    press(4'h1); press(4'h7); press(4'h3);
    check("t2_progress3", 32'(pif.progress), 32'h7);
    check("t2_entered3", 32'(pif.entered), 32'h1730);
    check("t2_no_early_fail", 32'(fail_cycles - f0), 32'd0);
    press(4'h2);
    cycles(5);
    check("t2_fail_pulse", 32'(fail_cycles - f0), 32'd1);
    check("t2_fail_count", 32'(pif.fail_count), 32'd1);
    check("t2_admitted", 32'(pif.admitted), 32'd0);
    check("t2_progress", 32'(pif.progress), 32'd0);

    // Lockout after the third consecutive failure.
    seq(16'h1732);
    check("t3_fail_count2", 32'(pif.fail_count), 32'd2);
    check("t3_not_locked", 32'(pif.locked), 32'd0);
    l0 = lock_cycles;
    seq(16'h1732);
    check("t3_locked", 32'(pif.locked), 32'd1);
    check("t3_fail_count3", 32'(pif.fail_count), 32'd3);
    seq(16'h1712);
    check("t3_ignored_admit", 32'(pif.admitted), 32'd0);
    check("t3_ignored_progress", 32'(pif.progress), 32'd0);
    check("t3_still_locked", 32'(pif.locked), 32'd1);
    cycles(1000);
    check("t3_lock_len", 32'(lock_cycles - l0), 32'd1000);
    check("t3_unlocked", 32'(pif.locked), 32'd0);
    check("t3_fail_count_clr", 32'(pif.fail_count), 32'd0);
    seq(16'h1712);
    check("t3_admit_after", 32'(pif.admitted), 32'd1);
    cycles(120);

    // Inter-digit timeout discards the entry, keeps fail_count.
    seq(16'h0000);
    check("t4_fail_count", 32'(pif.fail_count), 32'd1);
    press(4'h1); press(4'h7);
    check("t4_entered2", 32'(pif.entered), 32'h1700);
    cycles(480);
    check("t4_before_timeout", 32'(pif.progress), 32'h3);
    cycles(20);
    check("t4_progress_clr", 32'(pif.progress), 32'd0);
    check("t4_entered_clr", 32'(pif.entered), 32'd0);
    check("t4_fail_count_kept", 32'(pif.fail_count), 32'd1);
    seq(16'h1712);
    check("t4_admit", 32'(pif.admitted), 32'd1);
    check("t4_fail_count_clr", 32'(pif.fail_count), 32'd0);
    cycles(120);

    // Programming a new password.
    seq(16'h1712);
    pif.prog_req = 1'b1;
    press(4'h9);
    pif.prog_req = 1'b0;
    check("t5_prog_active", 32'(pif.prog_active), 32'd1);
    check("t5_admit_drop", 32'(pif.admitted), 32'd0);
    check("t5_start_not_captured", 32'(pif.progress), 32'd0);
    press(4'h4); press(4'h3);
    check("t5_prog_entered", 32'(pif.entered), 32'h4300);
    press(4'h2); press(4'h1);
    check("t5_prog_done", 32'(pif.prog_active), 32'd0);
    check("t5_prog_progress", 32'(pif.progress), 32'd0);
    seq(16'h1712);
    check("t5_old_rejected", 32'(pif.admitted), 32'd0);
    check("t5_old_fail_count", 32'(pif.fail_count), 32'd1);
    seq(16'h4321);
    check("t5_new_admits", 32'(pif.admitted), 32'd1);
    check("t5_new_fail_count", 32'(pif.fail_count), 32'd0);
    cycles(120);

    // Aborted programming leaves the password untouched.
    seq(16'h4321);
    pif.prog_req = 1'b1;
    press(4'h0);
    pif.prog_req = 1'b0;
    press(4'h5); press(4'h5);
    check("t6_partial_progress", 32'(pif.progress), 32'h3);
    cycles(520);
    check("t6_abort_prog", 32'(pif.prog_active), 32'd0);
    check("t6_abort_progress", 32'(pif.progress), 32'd0);
    seq(16'h4321);
    check("t6_old_still_admits", 32'(pif.admitted), 32'd1);
    cycles(120);

    // A held button yields a single digit.
    pif.digit_in  = 4'h8;
    pif.enter_btn = 1'b1;
    cycles(40);
    pif.enter_btn = 1'b0;
    cycles(4);
    check("t6_held_progress", 32'(pif.progress), 32'h1);
    check("t6_held_entered", 32'(pif.entered), 32'h8000);

    // Asynchronous reset mid-entry; password reverts to default.
    #2 rst = 1'b0;
    #1 check_all_zero("t6_async_rst");
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    seq(16'h4321);
    check("t6_prog_lost", 32'(pif.admitted), 32'd0);
    check("t6_prog_lost_fc", 32'(pif.fail_count), 32'd1);
    seq(16'h1712);
    check("t6_default_back", 32'(pif.admitted), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
